// File: rtl/tail_light_ctrl.sv
// tail_light_ctrl: turn-chase / hazard tail-light sequencer; brake overlay enabled by TAIL_LIGHT_BRAKE_EN
module tail_light_ctrl #(
    parameter int LAMPS    = 3,
    parameter int STEP_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             left,
    input  logic             right,
    input  logic             hazard,
`ifdef TAIL_LIGHT_BRAKE_EN
    input  logic             brake,
`endif
    output logic [LAMPS-1:0] left_lamps,
    output logic [LAMPS-1:0] right_lamps,
    output logic [1:0]       state_o
);
    localparam int DW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
    localparam int PW = $clog2(LAMPS + 1);
    typedef enum logic [1:0] {IDLE = 2'd0, LEFT = 2'd1, RIGHT = 2'd2, HAZ = 2'd3} state_t;
    state_t           state, state_n;
    logic [DW-1:0]    div;
    logic [PW-1:0]    pos, pos_n;
    logic             ph, ph_n, tick, hz, req, brk;
    logic [LAMPS-1:0] therm;

    assign tick    = div == DW'(STEP_DIV - 1);
    assign hz      = hazard | (left & right);
    assign req     = state == LEFT ? left : right;
    assign state_o = 2'(state);

    // free-running step prescaler
    always_ff @(posedge clk)
        if (!rst) div <= '0;
        else      div <= tick ? '0 : div + 1'b1;

    // state, chase position and hazard phase registers
    always_ff @(posedge clk)
        if (!rst) begin
            state <= IDLE;
            pos   <= '0;
            ph    <= 1'b0;
        end else begin
            state <= state_n;
            pos   <= pos_n;
            ph    <= ph_n;
        end

    // next-state logic, advanced only on step ticks; hazard wins, then left, then right
    always_comb begin
        state_n = state;
        pos_n   = pos;
        ph_n    = ph;
        if (tick) begin
            if (hz) begin
                state_n = HAZ;
                pos_n   = '0;
                ph_n    = state == HAZ ? ~ph : 1'b1;
            end else if (state == IDLE) begin
                state_n = left ? LEFT : right ? RIGHT : IDLE;
                pos_n   = (left | right) ? PW'(1) : '0;
            end else if (state == HAZ) begin
                state_n = IDLE;
                ph_n    = 1'b0;
            end else if (!req || pos == PW'(LAMPS)) begin
                state_n = IDLE;
                pos_n   = '0;
            end else begin
                pos_n   = pos + 1'b1;
            end
        end
    end

    // thermometer code: lamps 0..pos-1 lit
    always_comb
        for (int i = 0; i < LAMPS; i++) therm[i] = i < int'(pos);

`ifdef TAIL_LIGHT_BRAKE_EN
    // brake is sampled every cycle, independent of the step prescaler
    always_ff @(posedge clk)
        if (!rst) brk <= 1'b0;
        else      brk <= brake;
`else
    assign brk = 1'b0;
`endif

    // lamp decode from registers only; brake lights whichever side is not chasing, never during hazard
    always_comb begin
        left_lamps  = state == LEFT  ? therm : state == HAZ ? {LAMPS{ph}} : {LAMPS{brk}};
        right_lamps = state == RIGHT ? therm : state == HAZ ? {LAMPS{ph}} : {LAMPS{brk}};
    end
endmodule

// File: tb/tb_tail_light_ctrl.sv
// tb_tail_light_ctrl: directed checks of chase, hazard, abandon, prescaler and brake behaviour
module tb_tail_light_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic left = 1'b0, right = 1'b0, hazard = 1'b0;
    logic l1 = 1'b0, r1 = 1'b0, h1 = 1'b0;
    logic [2:0] ll, rl;
    logic [4:0] ll1, rl1;
    logic [1:0] st, st1;
    int n_chk = 0;
    int n_fail = 0;
`ifdef TAIL_LIGHT_BRAKE_EN
    logic brake = 1'b0, b1 = 1'b0;
`endif

    always #5 clk = ~clk;

    tail_light_ctrl #(.LAMPS(3), .STEP_DIV(1)) u0 (
        .clk(clk), .rst(rst), .left(left), .right(right), .hazard(hazard),
`ifdef TAIL_LIGHT_BRAKE_EN
        .brake(brake),
`endif
        .left_lamps(ll), .right_lamps(rl), .state_o(st)
    );

    tail_light_ctrl #(.LAMPS(5), .STEP_DIV(4)) u1 (
        .clk(clk), .rst(rst), .left(l1), .right(r1), .hazard(h1),
`ifdef TAIL_LIGHT_BRAKE_EN
        .brake(b1),
`endif
        .left_lamps(ll1), .right_lamps(rl1), .state_o(st1)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; left = 1'b1; l1 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            n_chk++;
            if ({ll, rl, st} !== {3'b000, 3'b000, 2'd0}) begin
                n_fail++;
                $display("FAIL reset[%0d] got %b/%b st=%0d want 000/000 st=0", k, ll, rl, st);
            end
            n_chk++;
            if ({ll1, rl1, st1} !== {5'b0, 5'b0, 2'd0}) begin
                n_fail++;
                $display("FAIL reset_w5[%0d] got %b/%b st=%0d want 00000/00000 st=0", k, ll1, rl1, st1);
            end
        end
        l1 = 1'b0;
    endtask

    task automatic test_left_chase;
        logic [2:0] exp_l [5] = '{3'b001, 3'b011, 3'b111, 3'b000, 3'b001};
        logic [1:0] exp_s [5] = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd1};
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            n_chk++;
            if ({ll, rl, st} !== {exp_l[k], 3'b000, exp_s[k]}) begin
                n_fail++;
                $display("FAIL left_chase[%0d] got %b/%b st=%0d want %b/000 st=%0d", k, ll, rl, st, exp_l[k], exp_s[k]);
            end
        end
    endtask

    task automatic test_hazard;
        logic [2:0] exp_f [4] = '{3'b111, 3'b000, 3'b111, 3'b000};
        step();
        n_chk++;
        if ({ll, st} !== {3'b011, 2'd1}) begin
            n_fail++;
            $display("FAIL haz_pre got %b st=%0d want 011 st=1", ll, st);
        end
        hazard = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            n_chk++;
            if ({ll, rl, st} !== {exp_f[k], exp_f[k], 2'd3}) begin
                n_fail++;
                $display("FAIL haz_flash[%0d] got %b/%b st=%0d want %b/%b st=3", k, ll, rl, st, exp_f[k], exp_f[k]);
            end
        end
        hazard = 1'b0; left = 1'b0;
        step();
        n_chk++;
        if ({ll, rl, st} !== {3'b000, 3'b000, 2'd0}) begin
            n_fail++;
            $display("FAIL haz_drop got %b/%b st=%0d want 000/000 st=0", ll, rl, st);
        end
        left = 1'b1; right = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_chk++;
            if ({ll, rl, st} !== {exp_f[k], exp_f[k], 2'd3}) begin
                n_fail++;
                $display("FAIL both_flash[%0d] got %b/%b st=%0d want %b/%b st=3", k, ll, rl, st, exp_f[k], exp_f[k]);
            end
        end
        left = 1'b0; right = 1'b0;
        step();
        n_chk++;
        if ({ll, rl, st} !== {3'b000, 3'b000, 2'd0}) begin
            n_fail++;
            $display("FAIL both_drop got %b/%b st=%0d want 000/000 st=0", ll, rl, st);
        end
    endtask

    task automatic test_abandon_switch;
        right = 1'b1;
        step();
        n_chk++;
        if ({ll, rl, st} !== {3'b000, 3'b001, 2'd2}) begin
            n_fail++;
            $display("FAIL right_start got %b/%b st=%0d want 000/001 st=2", ll, rl, st);
        end
        right = 1'b0; left = 1'b1;
        step();
        n_chk++;
        if ({ll, rl, st} !== {3'b000, 3'b000, 2'd0}) begin
            n_fail++;
            $display("FAIL switch_idle got %b/%b st=%0d want 000/000 st=0", ll, rl, st);
        end
        step();
        n_chk++;
        if ({ll, rl, st} !== {3'b001, 3'b000, 2'd1}) begin
            n_fail++;
            $display("FAIL switch_left got %b/%b st=%0d want 001/000 st=1", ll, rl, st);
        end
        left = 1'b0;
        step();
        n_chk++;
        if ({ll, rl, st} !== {3'b000, 3'b000, 2'd0}) begin
            n_fail++;
            $display("FAIL abandon got %b/%b st=%0d want 000/000 st=0", ll, rl, st);
        end
    endtask

    task automatic test_prescaler;
        logic [4:0] exp;
        int idx;
        rst = 1'b0;
        step();
        rst = 1'b1; l1 = 1'b1;
        for (int k = 1; k <= 28; k++) begin
            step();
            idx = k < 4 ? -1 : ((k - 4) / 4) % 6;
            exp = (idx < 0 || idx == 5) ? 5'b0 : 5'((1 << (idx + 1)) - 1);
            n_chk++;
            if ({ll1, rl1} !== {exp, 5'b0}) begin
                n_fail++;
                $display("FAIL prescale[%0d] got %b/%b want %b/00000", k, ll1, rl1, exp);
            end
        end
        l1 = 1'b0;
        for (int k = 29; k <= 32; k++) begin
            step();
            exp = k < 32 ? 5'b00001 : 5'b0;
            n_chk++;
            if (ll1 !== exp) begin
                n_fail++;
                $display("FAIL prescale_drop[%0d] got %b want %b", k, ll1, exp);
            end
        end
        h1 = 1'b1;
        for (int k = 33; k <= 36; k++) begin
            step();
            if (k == 34) h1 = 1'b0;
            n_chk++;
            if ({ll1, rl1, st1} !== {5'b0, 5'b0, 2'd0}) begin
                n_fail++;
                $display("FAIL short_pulse[%0d] got %b/%b st=%0d want 00000/00000 st=0", k, ll1, rl1, st1);
            end
        end
    endtask

`ifdef TAIL_LIGHT_BRAKE_EN
    task automatic test_brake;
        logic [8:0] exp [6] = '{{3'b111, 3'b111, 3'd0}, {3'b001, 3'b111, 3'd1}, {3'b011, 3'b111, 3'd1},
                                {3'b111, 3'b111, 3'd3}, {3'b000, 3'b000, 3'd3}, {3'b000, 3'b000, 3'd0}};
        brake = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            n_chk++;
            if ({ll, rl, 1'b0, st} !== exp[k]) begin
                n_fail++;
                $display("FAIL brake[%0d] got %b/%b st=%0d want %b/%b st=%0d", k, ll, rl, st, exp[k][8:6], exp[k][5:3], exp[k][2:0]);
            end
            if (k == 0) left = 1'b1;
            if (k == 2) hazard = 1'b1;
            if (k == 4) begin
                brake = 1'b0; hazard = 1'b0; left = 1'b0;
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_left_chase();
        test_hazard();
        test_abandon_switch();
        test_prescaler();
`ifdef TAIL_LIGHT_BRAKE_EN
        test_brake();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
